mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Control unit for the multicycle MIPS datapath (register file, enabled PC/IR flops, ALU-source and write-back muxes).
- A Moore main FSM sequences fetch, decode, execute, memory and write-back for each instruction and issues every enable and mux select.
- A combinational ALU decoder produces the ALU control.
- A `mem_ready` handshake lets the unified instruction/data memory stall the sequence.

Parameters:
- None. All encodings are fixed constants in the package.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op  in  6  instruction opcode, IR[31:26]
- funct  in  6  function field, IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access
- pcen  out  1  PC flop enable
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write enable (we3)
- memwrite  out  1  memory write strobe
- iord  out  1  address mux select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  write-data mux select: 0 = ALUOut, 1 = Data
- regdst  out  1  write-register mux select: 0 = rt, 1 = rd
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, debug only

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high: on a rising `clk` edge with `reset`=1, the state register loads FETCH.
  - While `reset`=1, `pcen`, `irwrite`, `regwrite`, `memwrite` and `illegal` are forced to 0, regardless of state.
  - After reset, `state`=0 (FETCH) and all other outputs take their FETCH values.
- Output style:
  - Moore outputs are decoded from state only.
  - Any output not listed for a state is 0.
  - `pcen = pcwrite | (branch & zero)`; `pcwrite` and `branch` are internal.
- States, their outputs and transitions:
  - FETCH(0): `iord`=0, `alusrca`=0, `alusrcb`=01, aluop=00, `pcsrc`=00. `irwrite` and `pcwrite` assert only when `mem_ready`=1. Stay while `mem_ready`=0; go to DECODE when `mem_ready`=1.
  - DECODE(1): `alusrca`=0, `alusrcb`=11, aluop=00. Next state by opcode:
    - lw (100011) or sw (101011) -> MEMADR
    - R-type (000000) -> RTYPEEX
    - beq (000100) -> BEQEX
    - addi (001000) -> ADDIEX
    - j (000010) -> JEX
    - any other opcode -> FETCH with `illegal`=1 for this cycle
  - MEMADR(2): `alusrca`=1, `alusrcb`=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD(3): `iord`=1. Stay until `mem_ready`=1, then MEMWB.
  - MEMWB(4): `regdst`=0, `memtoreg`=1, `regwrite`=1. Go to FETCH.
  - MEMWR(5): `iord`=1, `memwrite`=1, held while stalled. Stay until `mem_ready`=1, then FETCH.
  - RTYPEEX(6): `alusrca`=1, `alusrcb`=00, aluop=10. Go to RTYPEWB.
  - RTYPEWB(7): `regdst`=1, `memtoreg`=0, `regwrite`=1. Go to FETCH.
  - BEQEX(8): `alusrca`=1, `alusrcb`=00, aluop=01, `pcsrc`=01, branch=1. Go to FETCH.
  - ADDIEX(9): `alusrca`=1, `alusrcb`=10, aluop=00. Go to ADDIWB.
  - ADDIWB(10): `regdst`=0, `memtoreg`=0, `regwrite`=1. Go to FETCH.
  - JEX(11): `pcsrc`=10, pcwrite=1. Go to FETCH.
  - Unused encodings 12–15: all outputs 0; next state FETCH.
- Instruction latency with `mem_ready` tied to 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- `op` is sampled only in DECODE and MEMADR. IR is stable after FETCH, so no op latch is needed.
- Reset asserted mid-instruction:
  - The next edge returns to FETCH.
  - No write enable is asserted in the reset cycle.
  - An in-progress stalled `memwrite` is dropped.
- ALU decoder:
  - aluop 00 -> 010 (add)
  - aluop 01 -> 110 (subtract)
  - aluop 11 -> 010 (add)
  - aluop 10 decodes `funct`: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other -> 010. An unknown funct does not assert `illegal`.

Decomposition:
- Package `mc_ctrl_pkg`:
  - `statetype` enum (4-bit, encodings above)
  - opcode constants: OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - funct constants: ADD, SUB, AND, OR, SLT
  - aluop and alucontrol constants
- Sub-module `aludec_mc`: combinational, inputs `funct` and aluop, output `alucontrol`. It is instantiated once inside `mc_controller`.

Test Plan:
- Reset, then `mem_ready`=1, `op`=100011 (lw): state sequence 0,1,2,3,4,0. `irwrite`=`pcen`=1 only in FETCH; `regwrite`=1, `memtoreg`=1 only in state 4.
- `op`=000000, `funct`=101010 (slt): RTYPEEX shows `alucontrol`=111, `alusrca`=1, `alusrcb`=00. RTYPEWB shows `regdst`=1, `regwrite`=1.
- `op`=000100 (beq): in BEQEX, `zero`=1 gives `pcen`=1 with `pcsrc`=01; `zero`=0 gives `pcen`=0. Both cases return to FETCH.
- `op`=101011 (sw) with `mem_ready` low for 3 cycles in MEMWR: `memwrite`=1 and `iord`=1 held for 4 cycles, then FETCH. Stall in FETCH: `irwrite`=`pcen`=0 until `mem_ready`=1.
- `op`=111111: `illegal` pulses 1 in DECODE, next state FETCH, `regwrite`/`memwrite` never asserted.
- Reset asserted while in MEMWR with `mem_ready`=0: `memwrite`=0 in the reset cycle, state=0 after the edge, and a normal fetch follows.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS controller
// Purpose: state, opcode, funct, aluop and alucontrol constants.
// Ports: none (package).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } statetype;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/aludec_mc.sv
// rtl/aludec_mc.sv - combinational ALU control decoder
// Purpose: maps aluop and the R-type funct field to an ALU operation.
// Ports: funct[5:0] in, aluop[1:0] in, alucontrol[2:0] out.
module aludec_mc
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    ADD:     alucontrol = ALU_ADD;
                    SUB:     alucontrol = ALU_SUB;
                    AND:     alucontrol = ALU_AND;
                    OR:      alucontrol = ALU_OR;
                    SLT:     alucontrol = ALU_SLT;
                    // Unknown funct falls back to add; it is not flagged illegal.
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default:   alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS main FSM and control outputs
// Purpose: sequences fetch/decode/execute/memory/write-back and drives all
//          datapath enables and mux selects; memory can stall via mem_ready.
// Ports: clk, reset (sync, active-high), op, funct, zero, mem_ready in;
//        pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
//        alusrcb, pcsrc, alucontrol, illegal, state out.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    statetype   state_q;
    statetype   state_next;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;
    logic       illegal_raw;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next   = FETCH;
        aluop        = ALUOP_ADD;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                // IR and PC only load once the memory has returned the word.
                irwrite_raw = mem_ready;
                pcwrite     = mem_ready;
                state_next  = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
                    default: begin
                        illegal_raw = 1'b1;
                        state_next  = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord       = 1'b1;
                state_next = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                state_next   = mem_ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = RTYPEWB;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: regwrite_raw = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    aludec_mc u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

    // Reset masks every architectural write so a mid-instruction reset
    // (e.g. a stalled store) cannot corrupt state in the reset cycle.
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;
    assign irwrite  = irwrite_raw  & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign illegal  = illegal_raw  & ~reset;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed table-driven bench for mc_controller
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .state      (state)
    );

    // Packed output word: {state, pcen, irwrite, regwrite, memwrite, iord,
    // memtoreg, regdst, alusrca, alusrcb, pcsrc, alucontrol, illegal}
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    function automatic logic [19:0] o(input logic [3:0] st, input logic pc, ir, rw, mw, io, m2r, rd, asa,
                                      input logic [1:0] asb, pcs, input logic [2:0] alc, input logic ill);
        return {st, pc, ir, rw, mw, io, m2r, rd, asa, asb, pcs, alc, ill};
    endfunction

    function automatic logic [19:0] actual();
        return {state, pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};
    endfunction

    task automatic add(input logic r, input logic [5:0] opc, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [19:0] e);
        vec_t v;
        v.rst = r; v.op = opc; v.funct = fn; v.zero = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shorthand expected words for states whose outputs never depend on inputs
    function automatic logic [19:0] e_fetch(input logic go);
        return o(4'd0, go, go, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    endfunction
    function automatic logic [19:0] e_decode(input logic ill);
        return o(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, ill);
    endfunction

    task automatic add_rtype(input logic [5:0] fn, input logic [2:0] alc);
        add(0, RT, fn, 0, 1, e_fetch(1));
        add(0, RT, fn, 0, 1, e_decode(0));
        add(0, RT, fn, 0, 1, o(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alc, 0));
        add(0, RT, fn, 0, 1, o(4'd7, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0));
    endtask

    initial begin
        // reset row: write enables forced low, other FETCH values
        add(1, LW, 0, 0, 1, e_fetch(0));
        // lw, mem_ready=1: 0,1,2,3,4
        add(0, LW, 0, 0, 1, e_fetch(1));
        add(0, LW, 0, 0, 1, e_decode(0));
        add(0, LW, 0, 0, 1, o(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
        add(0, LW, 0, 0, 1, o(4'd3, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        add(0, LW, 0, 0, 1, o(4'd4, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        // R-type variants
        add_rtype(6'b101010, 3'b111);
        add_rtype(6'b100010, 3'b110);
        add_rtype(6'b100100, 3'b000);
        add_rtype(6'b100101, 3'b001);
        add_rtype(6'b111000, 3'b010);
        // beq taken / not taken
        add(0, BEQ, 0, 1, 1, e_fetch(1));
        add(0, BEQ, 0, 1, 1, e_decode(0));
        add(0, BEQ, 0, 1, 1, o(4'd8, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
        add(0, BEQ, 0, 0, 1, e_fetch(1));
        add(0, BEQ, 0, 0, 1, e_decode(0));
        add(0, BEQ, 0, 0, 1, o(4'd8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
        // addi
        add(0, ADDI, 0, 0, 1, e_fetch(1));
        add(0, ADDI, 0, 0, 1, e_decode(0));
        add(0, ADDI, 0, 0, 1, o(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
        add(0, ADDI, 0, 0, 1, o(4'd10, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        // j
        add(0, JMP, 0, 0, 1, e_fetch(1));
        add(0, JMP, 0, 0, 1, e_decode(0));
        add(0, JMP, 0, 0, 1, o(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0));
        // sw with three stalled MEMWR cycles
        add(0, SW, 0, 0, 1, e_fetch(1));
        add(0, SW, 0, 0, 1, e_decode(0));
        add(0, SW, 0, 0, 1, o(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
        for (int i = 0; i < 3; i++)
            add(0, SW, 0, 0, 0, o(4'd5, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        add(0, SW, 0, 0, 1, o(4'd5, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        // FETCH stall then illegal opcode
        add(0, BAD, 0, 0, 0, e_fetch(0));
        add(0, BAD, 0, 0, 0, e_fetch(0));
        add(0, BAD, 0, 0, 1, e_fetch(1));
        add(0, BAD, 0, 0, 1, e_decode(1));
        // reset in stalled MEMWR: memwrite dropped, iord still decoded
        add(0, SW, 0, 0, 1, e_fetch(1));
        add(0, SW, 0, 0, 1, e_decode(0));
        add(0, SW, 0, 0, 1, o(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
        add(0, SW, 0, 0, 0, o(4'd5, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        add(1, SW, 0, 0, 0, o(4'd5, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        add(0, JMP, 0, 0, 1, e_fetch(1));
        add(0, JMP, 0, 0, 1, e_decode(0));
        add(0, JMP, 0, 0, 1, o(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0));

        reset = 1'b1;
        step();
        step();
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
            zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d", i), {12'd0, actual()}, {12'd0, vecs[i].exp});
            step();
        end

        // lw with a stalled MEMRD, bounded wait for write-back
        begin
            int budget;
            reset = 1'b0; op = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
            #1;
            check("seq_fetch_state", {28'd0, state}, 32'd0);
            step(); step(); step();
            mem_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                #1;
                check($sformatf("memrd_hold%0d", i), {29'd0, state == 4'd3, iord, regwrite}, {29'd0, 3'b110});
                step();
            end
            mem_ready = 1'b1;
            budget = 0;
            while (state != 4'd4 && budget < 5) begin
                step();
                budget++;
            end
            check("memrd_release", {28'd0, state}, 32'd4);
            #1;
            check("memwb_regwrite", {30'd0, regwrite, memtoreg}, {30'd0, 2'b11});
            step();
            check("back_to_fetch", {28'd0, state}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
